gauss_filter_nxm: RTL and testbench

//  Parametrised N x M Gaussian convolution stage for the fusion video pipeline; successor to the fixed 3x3 filter.

---
 rtl/gauss_pkg.sv | 26 ++
 rtl/gauss_adder_tree.sv | 50 +++++
 rtl/gauss_filter_nxm.sv | 107 ++++++++++
 tb/tb_gauss_filter_nxm.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// Shared helpers for the N x M Gaussian filter: sizing functions and the identity bank.
package gauss_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Products, one level per adder-tree stage, then the normalise register.
  function automatic int calc_lat(input int n, input int m);
    return clog2(n * m) + 2;
  endfunction

  function automatic int calc_aw(input int dw, input int gw, input int n, input int m);
    return dw + gw + clog2(n * m);
  endfunction

  // Identity kernel: unity gain at the centre tap, zero elsewhere.
  function automatic logic [31:0] ident_coef(input int idx, input int n, input int m,
                                             input int gsum);
    return (idx == ((n - 1) / 2) * m + (m - 1) / 2) ? (32'd1 << gsum) : 32'd0;
  endfunction

endpackage

// File: rtl/gauss_adder_tree.sv
// Pipelined binary adder tree; leaves padded to a power of two so every path has L registers.
module gauss_adder_tree
  import gauss_pkg::*;
#(
  parameter int LEAVES = 9,
  parameter int IW     = 18
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [LEAVES*IW-1:0]            i_data,
  output logic [IW+clog2(LEAVES)-1:0]     o_sum
);

  localparam int L  = clog2(LEAVES);
  localparam int OW = IW + L;
  localparam int P  = 1 << L;

  logic [OW-1:0] w_leaf [P];

  for (genvar j = 0; j < P; j++) begin : g_leaf
    if (j < LEAVES) begin : g_in
      assign w_leaf[j] = OW'(i_data[j*IW +: IW]);
    end else begin : g_pad
      assign w_leaf[j] = '0;
    end
  end

  if (L == 0) begin : g_flat
    assign o_sum = w_leaf[0];
  end else begin : g_tree
    // Heap layout: node i sums children 2i and 2i+1; indices >= P are leaves.
    logic [OW-1:0] r_node [1:P-1];
    for (genvar i = 1; i < P; i++) begin : g_node
      logic [OW-1:0] w_a, w_b;
      if (2 * i >= P) begin : g_lf
        assign w_a = w_leaf[2*i-P];
        assign w_b = w_leaf[2*i+1-P];
      end else begin : g_nd
        assign w_a = r_node[2*i];
        assign w_b = r_node[2*i+1];
      end
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_node[i] <= '0;
        else          r_node[i] <= w_a + w_b;
      end
    end
    assign o_sum = r_node[1];
  end

endmodule

// File: rtl/gauss_filter_nxm.sv
// N x M Gaussian convolution stage with shadowed coefficient bank, rounding/saturating
// normalisation and a latency-matched centre pixel / sync / valid path.
module gauss_filter_nxm
  import gauss_pkg::*;
#(
  parameter int N           = 3,
  parameter int M           = 3,
  parameter int DATAWIDTH   = 8,
  parameter int G_DATAWIDTH = 10,
  parameter int G_SUM_W     = 8,
  parameter int CFG_AW      = 6
) (
  input  logic                       iclk,
  input  logic                       rst_n_i,
  input  logic                       isync,
  input  logic                       ivalid,
  input  logic [DATAWIDTH*N*M-1:0]   idata,
  input  logic                       cfg_we,
  input  logic [CFG_AW-1:0]          cfg_addr,
  input  logic [G_DATAWIDTH-1:0]     cfg_data,
  input  logic                       bypass,
  output logic                       osync,
  output logic                       ovalid,
  output logic [DATAWIDTH-1:0]       odata_g,
  output logic [DATAWIDTH-1:0]       odata_y
);

  localparam int NM   = N * M;
  localparam int LAT  = calc_lat(N, M);
  localparam int PW   = DATAWIDTH + G_DATAWIDTH;
  localparam int AW   = calc_aw(DATAWIDTH, G_DATAWIDTH, N, M);
  localparam int CIDX = ((N - 1) / 2) * M + (M - 1) / 2;
  localparam logic [AW:0] RND  = ((AW + 1)'(1) << G_SUM_W) >> 1;
  localparam logic [AW:0] PMAX = (AW + 1)'((1 << DATAWIDTH) - 1);

  logic [G_DATAWIDTH-1:0] r_shadow [NM];
  logic [G_DATAWIDTH-1:0] r_active [NM];
  logic [PW-1:0]          r_prod   [NM];
  logic [NM*PW-1:0]       w_prod_flat;

  for (genvar i = 0; i < NM; i++) begin : g_tap
    localparam logic [G_DATAWIDTH-1:0] IDENT = G_DATAWIDTH'(ident_coef(i, N, M, G_SUM_W));
    logic [G_DATAWIDTH-1:0] w_shadow_nxt;

    // A write on the sync cycle is folded in before the commit.
    assign w_shadow_nxt = (cfg_we && cfg_addr == CFG_AW'(i)) ? cfg_data : r_shadow[i];
    assign w_prod_flat[i*PW +: PW] = r_prod[i];

    always_ff @(posedge iclk or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_shadow[i] <= IDENT;
        r_active[i] <= IDENT;
        r_prod[i]   <= '0;
      end else begin
        r_shadow[i] <= w_shadow_nxt;
        if (isync) r_active[i] <= w_shadow_nxt;
        r_prod[i]   <= PW'(r_active[i]) * PW'(idata[i*DATAWIDTH +: DATAWIDTH]);
      end
    end
  end

  logic [AW-1:0] w_sum;

  gauss_adder_tree #(.LEAVES(NM), .IW(PW)) u_tree (
    .i_clk   (iclk),
    .i_rst_n (rst_n_i),
    .i_data  (w_prod_flat),
    .o_sum   (w_sum)
  );

  logic [AW:0]           w_rnd, w_q;
  logic [DATAWIDTH-1:0]  w_norm;

  assign w_rnd  = {1'b0, w_sum} + RND;
  assign w_q    = w_rnd >> G_SUM_W;
  assign w_norm = (w_q > PMAX) ? '1 : w_q[DATAWIDTH-1:0];

  logic [LAT:1]          r_vld_pipe, r_sync_pipe;
  logic [LAT-1:1]        r_byp_pipe;
  logic [DATAWIDTH-1:0]  r_cen_pipe [1:LAT];
  logic [DATAWIDTH-1:0]  r_g;

  // Side-band delay line; bypass stops one stage early to steer the output register.
  always_ff @(posedge iclk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_vld_pipe  <= '0;
      r_sync_pipe <= '0;
      r_byp_pipe  <= '0;
      r_g         <= '0;
      for (int k = 1; k <= LAT; k++) r_cen_pipe[k] <= '0;
    end else begin
      r_vld_pipe    <= {r_vld_pipe[LAT-1:1], ivalid};
      r_sync_pipe   <= {r_sync_pipe[LAT-1:1], isync};
      r_byp_pipe[1] <= bypass;
      r_cen_pipe[1] <= idata[CIDX*DATAWIDTH +: DATAWIDTH];
      for (int k = 2; k <= LAT; k++) r_cen_pipe[k] <= r_cen_pipe[k-1];
      for (int k = 2; k < LAT; k++)  r_byp_pipe[k] <= r_byp_pipe[k-1];
      r_g <= r_byp_pipe[LAT-1] ? r_cen_pipe[LAT-1] : w_norm;
    end
  end

  assign osync   = r_sync_pipe[LAT];
  assign ovalid  = r_vld_pipe[LAT];
  assign odata_g = r_g;
  assign odata_y = r_cen_pipe[LAT];

endmodule

// File: tb/tb_gauss_filter_nxm.sv
// Directed bench for gauss_filter_nxm: 3x3 instance plus a 5x5 instance sharing clock and reset.
module tb_gauss_filter_nxm;

  localparam int DW = 8, GW = 10, CAW = 6;
  localparam int LAT = 6, LAT5 = 7;

  logic iclk = 1'b0, rst_n_i = 1'b0;
  logic isync = 0, ivalid = 0, cfg_we = 0, bypass = 0;
  logic [9*DW-1:0] idata = '0;
  logic [CAW-1:0]  cfg_addr = '0;
  logic [GW-1:0]   cfg_data = '0;
  logic osync, ovalid;
  logic [DW-1:0] odata_g, odata_y;

  logic isync5 = 0, ivalid5 = 0, cfg_we5 = 0, bypass5 = 0;
  logic [25*DW-1:0] idata5 = '0;
  logic [CAW-1:0]   cfg_addr5 = '0;
  logic [GW-1:0]    cfg_data5 = '0;
  logic osync5, ovalid5;
  logic [DW-1:0] odata_g5, odata_y5;

  int n_chk = 0, n_err = 0;

  always #5 iclk = ~iclk;

  gauss_filter_nxm dut (
    .iclk(iclk), .rst_n_i(rst_n_i), .isync(isync), .ivalid(ivalid), .idata(idata),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .bypass(bypass),
    .osync(osync), .ovalid(ovalid), .odata_g(odata_g), .odata_y(odata_y));

  gauss_filter_nxm #(.N(5), .M(5)) dut5 (
    .iclk(iclk), .rst_n_i(rst_n_i), .isync(isync5), .ivalid(ivalid5), .idata(idata5),
    .cfg_we(cfg_we5), .cfg_addr(cfg_addr5), .cfg_data(cfg_data5), .bypass(bypass5),
    .osync(osync5), .ovalid(ovalid5), .odata_g(odata_g5), .odata_y(odata_y5));

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9*DW-1:0] win3(input logic [7:0] p0, input logic [7:0] pc,
                                           input logic [7:0] po);
    logic [9*DW-1:0] w;
    for (int i = 0; i < 9; i++) w[i*DW +: DW] = po;
    w[0 +: DW]    = p0;
    w[4*DW +: DW] = pc;
    return w;
  endfunction

  function automatic logic [25*DW-1:0] win5(input logic [7:0] pc, input logic [7:0] po);
    logic [25*DW-1:0] w;
    for (int i = 0; i < 25; i++) w[i*DW +: DW] = po;
    w[12*DW +: DW] = pc;
    return w;
  endfunction

  task automatic wr(input int a, input int d);
    cfg_addr = CAW'(a); cfg_data = GW'(d); cfg_we = 1; tick; cfg_we = 0;
  endtask

  task automatic do_sync(input bit wen, input int a, input int d, input string tag);
    cfg_we = wen; cfg_addr = CAW'(a); cfg_data = GW'(d); isync = 1; ivalid = 0; tick;
    cfg_we = 0; isync = 0;
    repeat (LAT-2) tick;
    chk({tag, " osync early"}, osync, 0);
    tick;
    chk({tag, " osync"}, osync, 1);
  endtask

  task automatic run_pix(input logic [9*DW-1:0] win, input bit byp, input string tag,
                         input int eg, input int ey);
    idata = win; bypass = byp; ivalid = 1; tick; ivalid = 0;
    repeat (LAT-2) tick;
    chk({tag, " ovalid early"}, ovalid, 0);
    tick;
    chk({tag, " ovalid"}, ovalid, 1);
    chk({tag, " odata_g"}, odata_g, eg);
    chk({tag, " odata_y"}, odata_y, ey);
  endtask

  task automatic run_pix5(input logic [25*DW-1:0] win, input bit byp, input string tag,
                          input int eg, input int ey);
    idata5 = win; bypass5 = byp; ivalid5 = 1; tick; ivalid5 = 0;
    repeat (LAT5-2) tick;
    chk({tag, " ovalid early"}, ovalid5, 0);
    tick;
    chk({tag, " ovalid"}, ovalid5, 1);
    chk({tag, " odata_g"}, odata_g5, eg);
    chk({tag, " odata_y"}, odata_y5, ey);
  endtask

  int kern [9] = '{16, 32, 16, 32, 64, 32, 16, 32, 16};
  int ep_g [6], ep_y [6];
  int p0, pc, k;
  bit b;

  initial begin
    // Reset state
    #12;
    chk("rst odata_g", odata_g, 0);
    chk("rst odata_y", odata_y, 0);
    chk("rst ovalid", ovalid, 0);
    chk("rst osync", osync, 0);
    @(posedge iclk); #1;
    rst_n_i = 1;
    tick;

    // Identity bank from reset
    run_pix(win3(200, 77, 200), 0, "ident", 77, 77);

    // Rounding: centre coefficient 128
    wr(4, 128);
    do_sync(0, 0, 0, "sync rnd");
    run_pix(win3(50, 3, 50), 0, "round 1.5", 2, 3);
    run_pix(win3(50, 1, 50), 0, "round 0.5", 1, 1);

    // Flat field with the 3x3 Gaussian kernel
    for (int i = 0; i < 9; i++) wr(i, kern[i]);
    do_sync(0, 0, 0, "sync gauss");
    run_pix(win3(100, 100, 100), 0, "flat", 100, 100);

    // Saturation, plus out-of-range addresses that must not alias
    for (int i = 0; i < 9; i++) wr(i, 57);
    wr(13, 0);
    wr(63, 0);
    do_sync(0, 0, 0, "sync sat");
    run_pix(win3(255, 255, 255), 0, "sat", 255, 255);
    run_pix(win3(100, 100, 100), 0, "k57 flat100", 200, 100);

    // Shadow bank: writes before sync stay invisible
    for (int i = 0; i < 9; i++) wr(i, (i == 4) ? 256 : 0);
    run_pix(win3(100, 100, 100), 0, "shadow hold", 200, 100);
    do_sync(1, 0, 256, "sync same-cycle");
    run_pix(win3(10, 20, 99), 0, "shadow commit", 30, 20);

    // Back-to-back stream, bypass alternating; bank is taps 0 and 4 at unity
    for (int e = 1; e <= 6 + LAT; e++) begin
      if (e <= 6) begin
        p0 = $urandom_range(0, 255);
        pc = $urandom_range(0, 255);
        b  = e[0];
        idata = win3(8'(p0), 8'(pc), 8'($urandom_range(0, 255)));
        bypass = b; ivalid = 1;
        ep_y[e-1] = pc;
        ep_g[e-1] = b ? pc : ((p0 + pc > 255) ? 255 : p0 + pc);
      end else begin
        ivalid = 0;
      end
      tick;
      if (e >= LAT && e - LAT < 6) begin
        k = e - LAT;
        chk($sformatf("stream%0d ovalid", k), ovalid, 1);
        chk($sformatf("stream%0d odata_g", k), odata_g, ep_g[k]);
        chk($sformatf("stream%0d odata_y", k), odata_y, ep_y[k]);
      end
    end
    bypass = 0;

    // Async reset in the middle of a stream
    for (int e = 0; e < 8; e++) begin
      idata = win3(8'(e + 1), 50, 0); ivalid = 1; tick;
    end
    chk("pre-rst ovalid", ovalid, 1);
    wr(4, 0);
    #2 rst_n_i = 0;
    #1;
    chk("async rst ovalid", ovalid, 0);
    chk("async rst odata_g", odata_g, 0);
    chk("async rst odata_y", odata_y, 0);
    @(posedge iclk); #1;
    rst_n_i = 1;
    idata = win3(10, 90, 0); ivalid = 1;
    for (int e = 1; e <= LAT; e++) begin
      tick;
      if (e < LAT) begin
        chk($sformatf("post-rst c%0d ovalid", e), ovalid, 0);
        chk($sformatf("post-rst c%0d odata_g", e), odata_g, 0);
      end else begin
        chk("post-rst ovalid", ovalid, 1);
        chk("post-rst identity", odata_g, 90);
      end
    end
    ivalid = 0;
    do_sync(0, 0, 0, "sync post-rst");
    run_pix(win3(10, 90, 0), 0, "lost shadow", 90, 90);

    // 5x5 instance: identity, then uniform bank of 10s
    run_pix5(win5(33, 250), 0, "5x5 ident", 33, 33);
    for (int i = 0; i < 25; i++) begin
      cfg_addr5 = CAW'(i); cfg_data5 = GW'(10); cfg_we5 = 1; tick;
    end
    cfg_we5 = 0; isync5 = 1; tick; isync5 = 0;
    run_pix5(win5(200, 200), 0, "5x5 flat", 195, 200);
    run_pix5(win5(0, 100), 0, "5x5 ring", 94, 0);
    run_pix5(win5(200, 200), 1, "5x5 bypass", 200, 200);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
